// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, command codes, frame length and command check shared by spi_slave_if
package spi_pkg;
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam int RX_BITS = 10;
    function automatic logic cmd_ok(input state_t s, input logic [1:0] c);
        return s == WRITE ? (c == CMD_WR_ADDR || c == CMD_WR_DATA) :
               s == READ_ADD ? c == CMD_RD_ADDR : s == READ_DATA && c == CMD_RD_DATA;
    endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: serial-in/parallel-out and parallel-load/serial-out register with bit counter and done flag
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_pdata,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_pnext,
    output logic         o_sout,
    output logic         o_done
);
    localparam int CW = $clog2(W);
    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_cnt;
    assign o_pnext = {r_sh[W-2:0], i_sin};
    assign o_sout  = r_sh[W-1];
    assign o_done  = i_shift && r_cnt == CW'(W - 1);
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_pdata;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sh  <= o_pnext;
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end for syn_ram; defining SPI_CMD_CHECK_EN adds command checking and cmd_err
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int ADD_SIZE = RX_BITS - 2
) (
    input  logic                clk_spi,
    input  logic                rst_spi,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [ADD_SIZE+1:0] rx_data,
    output logic                rx_valid,
    input  logic [ADD_SIZE-1:0] tx_data,
    input  logic                tx_valid
`ifdef SPI_CMD_CHECK_EN
    ,
    output logic                cmd_err
`endif
);
    state_t              r_state, w_next;
    logic                r_rd_seen, r_rx_done, r_waiting, r_tx_busy, r_miso, r_rx_valid;
    logic [1:0]          r_wait;
    logic [ADD_SIZE+1:0] r_rx_data, w_rx_next;
    logic [ADD_SIZE-1:0] w_tx_pnext;
    logic                w_rx_shift, w_rx_done, w_ok, w_cap, w_tx_shift, w_tx_sout, w_tx_done, w_rx_sout;
    logic                w_unused;
    assign MISO     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign w_unused = ^{w_rx_sout, w_tx_pnext};
`ifdef SPI_CMD_CHECK_EN
    logic r_cmd_err;
    assign w_ok    = cmd_ok(r_state, w_rx_next[ADD_SIZE+1:ADD_SIZE]);
    assign cmd_err = r_cmd_err;
    always_ff @(posedge clk_spi) r_cmd_err <= !rst_spi && (r_cmd_err || (w_rx_done && !w_ok));
`else
    assign w_ok = 1'b1;
`endif
    always_ff @(posedge clk_spi) r_state <= rst_spi ? IDLE : w_next;
    always_comb begin
        w_next = SS_n ? IDLE :
                 r_state == IDLE ? CHK_CMD :
                 r_state == CHK_CMD ? (MOSI ? (r_rd_seen ? READ_DATA : READ_ADD) : WRITE) : r_state;
    end
    // a read-data capture is only allowed once two cycles have passed since the strobe
    always_comb begin
        w_rx_shift = !SS_n && !r_rx_done && r_state inside {WRITE, READ_ADD, READ_DATA};
        w_cap      = !SS_n && r_waiting && r_wait == 2'd2 && tx_valid;
        w_tx_shift = !SS_n && r_tx_busy;
    end
    spi_shift_reg #(.W(ADD_SIZE + 2)) u_rx (
        .clk(clk_spi), .rst(rst_spi), .i_clr(SS_n), .i_load(1'b0), .i_pdata('0),
        .i_shift(w_rx_shift), .i_sin(MOSI), .o_pnext(w_rx_next), .o_sout(w_rx_sout), .o_done(w_rx_done)
    );
    spi_shift_reg #(.W(ADD_SIZE)) u_tx (
        .clk(clk_spi), .rst(rst_spi), .i_clr(SS_n), .i_load(w_cap), .i_pdata(tx_data),
        .i_shift(w_tx_shift), .i_sin(1'b0), .o_pnext(w_tx_pnext), .o_sout(w_tx_sout), .o_done(w_tx_done)
    );
    always_ff @(posedge clk_spi) begin
        if (rst_spi) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rd_seen  <= 1'b0;
            r_rx_done  <= 1'b0;
            r_waiting  <= 1'b0;
            r_wait     <= 2'd0;
            r_tx_busy  <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_rx_valid <= w_rx_done && w_ok;
            if (w_rx_done && w_ok) r_rx_data <= w_rx_next;
            if (SS_n) begin
                r_rx_done <= 1'b0;
                r_waiting <= 1'b0;
                r_tx_busy <= 1'b0;
            end else begin
                if (w_rx_done) r_rx_done <= 1'b1;
                if (w_rx_done && w_ok && r_state == READ_DATA) begin
                    r_waiting <= 1'b1;
                    r_wait    <= 2'd0;
                end else if (w_cap) begin
                    r_waiting <= 1'b0;
                    r_tx_busy <= 1'b1;
                end else if (r_waiting && r_wait != 2'd2) begin
                    r_wait <= r_wait + 2'd1;
                end
                if (w_tx_done) r_tx_busy <= 1'b0;
            end
            r_miso <= w_tx_shift ? w_tx_sout : 1'b0;
            if (w_rx_done && w_ok && r_state == READ_ADD) r_rd_seen <= 1'b1;
            else if (w_tx_done) r_rd_seen <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: randomized scoreboard bench for spi_slave_if with a frame-level reference model
module tb_spi_slave_if;
    logic       clk, rst_spi, SS_n, MOSI, MISO, rx_valid, tx_valid;
    logic [9:0] rx_data;
    logic [7:0] tx_data;
`ifdef SPI_CMD_CHECK_EN
    logic cmd_err;
    bit   err_exp = 0;
`endif
    typedef struct {
        logic [9:0]  w;
        int          c;
        bit          chk;
        logic [15:0] miso;
    } exp_t;
    exp_t sb[$];
    int   n_tests = 0, n_fail = 0, cyc = 0;
    bit   rd_seen = 0;

    spi_slave_if dut (
        .clk_spi(clk), .rst_spi(rst_spi), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef SPI_CMD_CHECK_EN
        , .cmd_err(cmd_err)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Whole frame: SS_n low, command bit, 10 word bits, then a 16-cycle RAM response window.
    task automatic frame(input logic cmd, input logic [9:0] w, input bit stale, input int j,
                         input logic [7:0] b, input bit chk);
        int          kind, oc;
        bit          ok;
        logic        v[16];
        logic [7:0]  dat[16];
        logic [7:0]  cap;
        logic [15:0] em;
        kind = !cmd ? 0 : rd_seen ? 2 : 1;
        ok = 1;
`ifdef SPI_CMD_CHECK_EN
        ok = kind == 0 ? !w[9] : w[9:8] == (kind == 1 ? 2'b10 : 2'b11);
        if (!ok) err_exp = 1;
`endif
        oc = 0;
        cap = 0;
        for (int o = 15; o >= 0; o--) begin
            v[o] = (o >= j) || stale;
            dat[o] = o >= j ? b : stale ? 8'hFF : 8'($urandom);
            if (o >= 2 && v[o]) begin
                oc = o;
                cap = dat[o];
            end
        end
        em = (kind == 2 && ok) ? 16'({cap, 8'h00} >> (oc + 1)) : 16'h0000;
        if (ok) begin
            sb.push_back('{w, cyc + 12, chk, em});
            if (kind == 1) rd_seen = 1;
            else if (kind == 2 && chk) rd_seen = 0;
        end
        tx_valid = stale;
        tx_data = stale ? 8'hFF : 8'($urandom);
        SS_n = 0;
        MOSI = cmd;
        tick;
        tick;
        for (int i = 9; i >= 0; i--) begin
            MOSI = w[i];
            tick;
        end
        if (!chk) return;
        for (int o = 0; o < 16; o++) begin
            tx_valid = v[o];
            tx_data = dat[o];
            MOSI = 1'($urandom);
            tick;
        end
        tx_valid = 0;
        tick;
        SS_n = 1;
        tick;
    endtask

    task automatic abort(input logic cmd, input int nbits);
        SS_n = 0;
        MOSI = cmd;
        tick;
        tick;
        for (int i = 0; i < nbits; i++) begin
            MOSI = 1'($urandom);
            tick;
        end
        SS_n = 1;
        MOSI = 0;
        repeat (12) tick;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [15:0] got;
        logic        extra;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rx_valid: rx_data=%0h with no frame expected (cycle %0d)", rx_data, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.w));
                    check("strobe_cycle", cyc, e.c);
                    if (e.chk) begin
                        got = 0;
                        extra = 0;
                        for (int i = 1; i <= 16; i++) begin
                            @(negedge clk);
                            got[16-i] = MISO;
                            extra |= rx_valid;
                        end
                        check("miso_stream", 32'(got), 32'(e.miso));
                        check("rx_valid_width", 32'(extra), 32'd0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic       c;
        logic [1:0] top;
        logic [7:0] b;
        int         k;
        rst_spi = 1;
        SS_n = 1;
        MOSI = 0;
        tx_valid = 0;
        tx_data = 0;
        repeat (3) tick;
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst_spi = 0;
        tick;
        frame(0, 10'h0A5, 0, 1, 8'h00, 1);
        frame(0, 10'h13C, 0, 2, 8'h5A, 1);
        frame(1, 10'h2A5, 0, 1, 8'h77, 1);
        frame(1, 10'h300, 0, 1, 8'h3C, 1);
        frame(1, 10'h2A5, 0, 1, 8'h99, 1);
        frame(1, 10'h381, 1, 1, 8'h81, 1);
        abort(0, 5);
        frame(0, 10'h055, 0, 3, 8'h00, 1);
        frame(1, 10'h211, 0, 1, 8'h00, 1);
        abort(1, 5);
        frame(1, 10'h3C3, 1, 4, 8'hC3, 1);
        for (int n = 0; n < 30; n++) begin
            c = 1'($urandom);
            k = !c ? 0 : rd_seen ? 2 : 1;
            top = k == 0 ? {1'b0, 1'($urandom)} : k == 1 ? 2'b10 : 2'b11;
            if ($urandom_range(3) == 0) top = 2'($urandom);
            if ($urandom_range(5) == 0) abort(c, $urandom_range(9));
            else frame(c, {top, 8'($urandom)}, 1'($urandom), $urandom_range(5, 1), 8'($urandom), 1);
        end
        if (!rd_seen) frame(1, {2'b10, 8'($urandom)}, 0, 1, 8'h00, 1);
        b = 8'($urandom) | 8'h20;
        frame(1, {2'b11, 8'($urandom)}, 0, 1, b, 0);
        tx_valid = 1;
        tx_data = b;
        repeat (6) tick;
        check("miso_before_reset", 32'(MISO), 32'(b[5]));
        rst_spi = 1;
        SS_n = 1;
        tx_valid = 0;
        tick;
        rst_spi = 0;
        rd_seen = 0;
        check("midreset_miso", 32'(MISO), 32'd0);
        check("midreset_rx_valid", 32'(rx_valid), 32'd0);
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        tick;
        frame(1, 10'h2F0, 0, 1, 8'hE7, 1);
        frame(1, 10'h30F, 0, 2, 8'hE7, 1);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef SPI_CMD_CHECK_EN
        check("cmd_err", 32'(cmd_err), 32'(err_exp));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end that feeds syn_ram.
- Deserialises MOSI frames into 10-bit command words (rx_data/rx_valid) for the RAM.
- On read-data commands, captures the RAM's 8-bit response (tx_data/tx_valid) and shifts it out on MISO.
- Sits between the SPI pins and syn_ram; clk_spi is the SPI serial clock (one bit per cycle).

Parameters:
- ADD_SIZE, 8, address/data byte width; rx_data width is ADD_SIZE+2.

Ports:
- clk_spi  input  1  clock; all logic on posedge.
- rst_spi  input  1  reset, synchronous, active-high.
- SS_n  input  1  slave select, active-low; high aborts any frame.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  ADD_SIZE+2  command word {cmd[1:0], payload[7:0]} to RAM din.
- rx_valid  output  1  one-cycle strobe; rx_data valid.
- tx_data  input  ADD_SIZE  read byte from RAM dout.
- tx_valid  input  1  RAM read-data valid (level; may stay high from earlier reads).

Behaviour:
- Reset (rst_spi=1 at posedge) values:
  - state=IDLE; MISO=0; rx_data=0; rx_valid=0.
  - rd_addr_seen=0; bit counter=0.
- Reset has priority over all other inputs.
- States and transitions:
  - IDLE: SS_n=0 -> CHK_CMD.
  - CHK_CMD: samples MOSI.
    - MOSI=0 -> WRITE.
    - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
    - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
  - WRITE / READ_ADD:
    - Sample 10 MOSI bits into shift register, rx_data[9] first.
    - Cycle after the 10th sample: rx_data updated and rx_valid=1 for exactly one cycle.
    - READ_ADD completion sets rd_addr_seen=1.
    - Further bits are ignored until SS_n=1.
  - READ_DATA:
    - Collect 10 bits and pulse rx_valid as above, then enter the wait phase.
    - Wait phase: capture tx_data in the first cycle that is >=2 cycles after the rx_valid pulse and has tx_valid=1. This ignores a stale tx_valid level.
    - Then drive the captured byte on MISO, bit 7 first, one bit per cycle for 8 cycles, registered.
    - After the 8th bit: MISO=0 and rd_addr_seen cleared.
    - The block then holds until SS_n=1.
- SS_n=1 in any state: next state IDLE, bit counter cleared, MISO=0.
  - A partial frame produces no rx_valid and leaves rd_addr_seen unchanged.
  - An rx_valid already scheduled for this cycle still completes.
- rx_data holds its last value between strobes.
- MISO=0 whenever the block is not shifting read data.
- Latency:
  - Write frame: SS_n low edge to rx_valid = 12 cycles (1 IDLE + 1 CHK_CMD + 10 bits).
  - Read data: first MISO bit 1 cycle after capture.

Optional Feature:
- Macro: SPI_CMD_CHECK_EN.
- With the macro:
  - At frame completion, rx_data[9:8] is checked against state: WRITE expects 00/01, READ_ADD expects 10, READ_DATA expects 11.
  - On mismatch, rx_valid is suppressed and the rd_addr_seen update is skipped.
  - The extra output port cmd_err (1 bit) is present: sticky, set on mismatch, cleared only by rst_spi.
- Without the macro: no check, no cmd_err port, every completed frame strobes rx_valid.

Decomposition:
- Shared package (spi_pkg):
  - State encoding typedef (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - Command constants: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - Frame length constant RX_BITS=10.
- Natural sub-module: spi_shift_reg, a parameterised serial-in/parallel-out plus parallel-load/serial-out register with bit counter and done flag. It is instantiated once for rx and once for tx.

Test Plan:
- Write address: SS_n low, MOSI 0 then 00_1010_0101 -> rx_data=0x0A5 and rx_valid high 1 cycle, 12 cycles after SS_n fall; MISO stays 0.
- Write data: MOSI 0 then 01_0011_1100 -> rx_data=0x13C; rd_addr_seen stays 0.
- Read sequence, frame 1: MOSI 1 then 10_1010_0101 -> rx_data=0x2A5, rd_addr_seen=1.
- Read sequence, frame 2: MOSI 1 then 11_0000_0000 -> rx_data=0x300; RAM model returns tx_data=0x3C with tx_valid 1 cycle later -> MISO 0,0,1,1,1,1,0,0 on consecutive cycles; rd_addr_seen=0 afterwards.
- Stale tx_valid: hold tx_valid=1 with tx_data=0xFF before the rx_valid of a read-data frame, then change tx_data to 0x81 one cycle after the strobe -> MISO shifts 0x81, not 0xFF.
- Abort: raise SS_n after 5 bits of a WRITE frame -> no rx_valid, state IDLE next cycle; the next full frame completes normally.
- Reset mid-READ_DATA shift (rst_spi=1 for one cycle) -> MISO=0, rx_valid=0, rd_addr_seen=0 at the following cycle.
- With SPI_CMD_CHECK_EN: MOSI 0 then 10_xxxx_xxxx -> no rx_valid, cmd_err=1 and it stays set.
